inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Front end feeding the decoder: fetches 32-bit instruction words from the memory controller,
//  attaches a static branch prediction, buffers {inst,pc,pd} in a small FIFO, and hands one
//  instruction per cycle to the decoder when downstream (ROB/RS) is not full.
//  The ROB redirects it on mispredict via clear + target pc.
// PARAMETERS
//  IQ_DEPTH   4   instruction-queue entries; power of two, >= 2
//  IQ_AW      2   log2(IQ_DEPTH)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous reset, active-high
//  rdy           in   1   global enable; 0 freezes all state
//  iFULL         in   1   downstream full; 1 blocks issue to decoder
//  iROB_clr      in   1   mispredict flush
//  iROB_pc       in   32  redirect target, valid with iROB_clr
//  oMC_en        out  1   fetch request to memory controller
//  oMC_addr      out  32  fetch address (word aligned)
//  iMC_valid     in   1   response valid, one cycle per request
//  iMC_inst      in   32  fetched word, valid with iMC_valid
//  oDEC_en       out  1   instruction valid to decoder (single-cycle pulse per instruction)
//  oDEC_inst     out  32  instruction word
//  oDEC_pc       out  32  pc of instruction
//  oDEC_pd       out  1   predicted taken
// BEHAVIOUR
//  Reset: pc=0, queue empty (count=0), state IDLE, oMC_en=0, oMC_addr=0, oDEC_en=0,
//    oDEC_inst=0, oDEC_pc=0, oDEC_pd=0. rst has priority over rdy and iROB_clr.
//  rdy=0: no register changes; outputs hold. Memory controller is frozen by the same rdy.
//  FSM (all transitions on clk edge with rdy=1):
//    IDLE: if !iROB_clr and count<IQ_DEPTH -> oMC_en<=1, oMC_addr<=pc, go WAIT.
//    WAIT: oMC_en/oMC_addr held stable until iMC_valid. On iMC_valid: push {iMC_inst,pc,pd},
//          pc<=next_pc, oMC_en<=0, go IDLE. Next request earliest one cycle later.
//    DROP: outstanding response discarded; on iMC_valid: no push, oMC_en<=0, go IDLE.
//  Prediction (on iMC_inst): opcode 1101111 (JAL): pd=1, next_pc=pc+J-imm.
//    opcode 1100011 with inst[31]=1 (backward branch): pd=1, next_pc=pc+B-imm.
//    All else (incl. JALR, forward branch): pd=0, next_pc=pc+4. Adds are mod 2^32.
//  Issue: each edge, if count>0 and !iFULL and !iROB_clr: pop head onto oDEC_* with
//    oDEC_en<=1; otherwise oDEC_en<=0 (oDEC_inst/pc/pd hold). Max one pop per cycle.
//  Latency: iMC_valid in cycle c -> entry in queue c+1 -> oDEC_en high earliest c+2.
//  Full: request only issued when count<IQ_DEPTH at IDLE; since at most one request is
//    outstanding, a push always fits. Simultaneous push+pop: count unchanged, both take effect.
//  Empty: no pop, oDEC_en=0. Pointers wrap modulo IQ_DEPTH.
//  Flush (iROB_clr=1, rdy=1): queue emptied (count=0, pointers reset), oDEC_en<=0, pc<=iROB_pc.
//    IDLE -> stays IDLE (request from new pc next cycle). WAIT -> DROP, oMC_en held until
//    the pending response returns, then discarded. Flush in DROP: stay DROP, pc updated.
//    Flush coincident with iMC_valid in WAIT: response discarded, go IDLE, no push.
//  Reset mid-request: state IDLE immediately; a late iMC_valid in IDLE is ignored.
// TESTING
//  Reset, memory returns 0x00000013 (addi) after 2 cycles -> oMC_addr=0,4,8...; oDEC_pc=0,4,8
//    with oDEC_pd=0, oDEC_en 2 cycles after each iMC_valid.
//  Word at pc 0x10 = JAL +0x100 -> oDEC_pd=1 for pc 0x10; next oMC_addr=0x110.
//  BEQ at 0x20 with imm=-8 -> pd=1, next addr 0x18; BEQ imm=+8 -> pd=0, next addr 0x24.
//  iFULL=1 held 10 cycles -> exactly 4 entries buffered, oMC_en stays 0; iFULL drop ->
//    4 consecutive oDEC_en pulses with pcs in order, fetching resumes.
//  iROB_clr with iROB_pc=0x200 while in WAIT -> pending response not issued, queue empty,
//    next oMC_addr=0x200, first oDEC_pc after clear =0x200.
//  rdy=0 for 3 cycles mid-WAIT -> all outputs frozen, sequence resumes unchanged.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: requests words from the memory controller one
// at a time, attaches a static branch prediction, buffers {inst, pc, pd} in a
// small FIFO and hands one instruction per cycle to the decoder.
`timescale 1ns/1ps

module inst_fetcher #(
    parameter int IQ_DEPTH = 4,
    parameter int IQ_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iFULL,
    input  logic        iROB_clr,
    input  logic [31:0] iROB_pc,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_valid,
    input  logic [31:0] iMC_inst,
    output logic        oDEC_en,
    output logic [31:0] oDEC_inst,
    output logic [31:0] oDEC_pc,
    output logic        oDEC_pd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // free to issue a request
        ST_WAIT = 2'd1,  // request outstanding, response will be queued
        ST_DROP = 2'd2   // request outstanding, response will be discarded
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pd;
    } iq_entry_t;

    localparam logic [6:0]     OP_JAL    = 7'b1101111;
    localparam logic [6:0]     OP_BRANCH = 7'b1100011;
    localparam logic [IQ_AW:0] LP_DEPTH  = (IQ_AW + 1)'(IQ_DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_pc;
    logic            r_mc_en;
    logic [31:0]     r_mc_addr;
    logic [IQ_AW-1:0] r_wptr;
    logic [IQ_AW-1:0] r_rptr;
    logic [IQ_AW:0]  r_count;
    iq_entry_t       r_iq [IQ_DEPTH];
    logic            r_dec_en;
    logic [31:0]     r_dec_inst;
    logic [31:0]     r_dec_pc;
    logic            r_dec_pd;

    logic            w_req;
    logic            w_push;
    logic            w_resp_done;
    logic            w_pop;
    logic [31:0]     w_j_imm;
    logic [31:0]     w_b_imm;
    logic            w_pd;
    logic [31:0]     w_next_pc;

    assign oMC_en    = r_mc_en;
    assign oMC_addr  = r_mc_addr;
    assign oDEC_en   = r_dec_en;
    assign oDEC_inst = r_dec_inst;
    assign oDEC_pc   = r_dec_pc;
    assign oDEC_pd   = r_dec_pd;

    // Sign-extended immediates of the returning word (J-type and B-type layouts).
    assign w_j_imm = {{11{iMC_inst[31]}}, iMC_inst[31], iMC_inst[19:12],
                      iMC_inst[20], iMC_inst[30:21], 1'b0};
    assign w_b_imm = {{19{iMC_inst[31]}}, iMC_inst[31], iMC_inst[7],
                      iMC_inst[30:25], iMC_inst[11:8], 1'b0};

    // A pop never happens on an empty queue or while the ROB flushes.
    assign w_pop = (r_count != '0) && !iFULL && !iROB_clr;

    // Static prediction: JAL and backward branches taken, everything else falls through.
    always_comb begin
        // NOTE: every signal gets a default before the case logic so no path leaves it unassigned (no latch).
        w_pd      = 1'b0;
        w_next_pc = r_pc + 32'd4;
        if (iMC_inst[6:0] == OP_JAL) begin
            w_pd      = 1'b1;
            w_next_pc = r_pc + w_j_imm;
        end else if (iMC_inst[6:0] == OP_BRANCH && iMC_inst[31]) begin
            w_pd      = 1'b1;
            w_next_pc = r_pc + w_b_imm;
        end
    end

    // Next-state logic and per-cycle fetch control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only one request is ever in flight, so count<DEPTH guarantees room for its word.
                if (!iROB_clr && r_count < LP_DEPTH) begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iMC_valid) begin
                    w_resp_done = 1'b1;
                    w_push      = !iROB_clr;
                    w_state_nxt = ST_IDLE;
                end else if (iROB_clr) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (iMC_valid) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register; rdy low freezes it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Memory request handshake: raise with the current pc, hold until the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mc_en   <= 1'b0;
            r_mc_addr <= '0;
        end else if (rdy) begin
            if (w_req) begin
                r_mc_en   <= 1'b1;
                r_mc_addr <= r_pc;
            end else if (w_resp_done) begin
                r_mc_en   <= 1'b0;
            end
        end
    end

    // Fetch pc: redirect on flush, otherwise advance when a word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                r_pc <= iROB_pc;
            end else if (w_push) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Queue pointers and occupancy; a flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; entries are only read while r_count says they are valid.
        if (!rst && rdy && w_push) begin
            r_iq[r_wptr] <= '{inst: iMC_inst, pc: r_pc, pd: w_pd};
        end
    end

    // Issue to decoder: one pop per cycle, payload holds when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_en   <= 1'b0;
            r_dec_inst <= '0;
            r_dec_pc   <= '0;
            r_dec_pd   <= 1'b0;
        end else if (rdy) begin
            r_dec_en <= w_pop;
            if (w_pop) begin
                r_dec_inst <= r_iq[r_rptr].inst;
                r_dec_pc   <= r_iq[r_rptr].pc;
                r_dec_pd   <= r_iq[r_rptr].pd;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a memory responder with two-cycle latency,
// a decoder-side monitor, and a linear sequence of checked scenarios.
`timescale 1ns/1ps

module tb_inst_fetcher;

    localparam logic [31:0] ADDI    = 32'h0000_0013;
    localparam logic [31:0] JAL100  = 32'h1000_006F;  // jal x0, +0x100
    localparam logic [31:0] BEQ_NEG = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] BEQ_POS = 32'h0000_0463;  // beq x0,x0,+8
    localparam int          MEM_LAT = 2;
    localparam int          TMO     = 60;

    typedef struct {
        logic [31:0] pc;
        logic        pd;
        logic [31:0] inst;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst, rdy, iFULL, iROB_clr;
    logic [31:0] iROB_pc;
    logic        oMC_en;
    logic [31:0] oMC_addr;
    logic        iMC_valid = 1'b0;
    logic [31:0] iMC_inst  = '0;
    logic        oDEC_en;
    logic [31:0] oDEC_inst, oDEC_pc;
    logic        oDEC_pd;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        rdy_q = 1'b0;
    logic        rst_q = 1'b1;
    bit          mem_on = 1'b1;
    logic        man_valid = 1'b0;
    logic [31:0] man_inst  = '0;
    int          mem_cnt = 0;
    logic [31:0] beq_word = BEQ_NEG;
    logic [31:0] req_q [$];
    dec_t        dec_q [$];

    inst_fetcher #(.IQ_DEPTH(4), .IQ_AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .iFULL     (iFULL),
        .iROB_clr  (iROB_clr),
        .iROB_pc   (iROB_pc),
        .oMC_en    (oMC_en),
        .oMC_addr  (oMC_addr),
        .iMC_valid (iMC_valid),
        .iMC_inst  (iMC_inst),
        .oDEC_en   (oDEC_en),
        .oDEC_inst (oDEC_inst),
        .oDEC_pc   (oDEC_pc),
        .oDEC_pd   (oDEC_pd)
    );

    always #5 clk = ~clk;

    // What the DUT saw at the last rising edge.
    always @(posedge clk) begin
        rdy_q <= rdy;
        rst_q <= rst;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return JAL100;
            32'h20:  return beq_word;
            default: return ADDI;
        endcase
    endfunction

    // Memory controller model: logs each request, answers MEM_LAT cycles later, frozen by rdy.
    always @(negedge clk) begin
        if (!mem_on) begin
            iMC_valid = man_valid;
            iMC_inst  = man_inst;
            mem_cnt   = 0;
        end else if (rst_q) begin
            iMC_valid = 1'b0;
            mem_cnt   = 0;
        end else if (rdy_q) begin
            if (iMC_valid) begin
                iMC_valid = 1'b0;
                mem_cnt   = 0;
            end else if (oMC_en) begin
                mem_cnt++;
                if (mem_cnt == 1) req_q.push_back(oMC_addr);
                if (mem_cnt == MEM_LAT) begin
                    iMC_valid = 1'b1;
                    iMC_inst  = mem_word(oMC_addr);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Decoder-side monitor: one record per issued instruction.
    always @(negedge clk) begin
        if (!rst_q && rdy_q && oDEC_en)
            dec_q.push_back('{pc: oDEC_pc, pd: oDEC_pd, inst: oDEC_inst});
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_dec(input string tag, input logic [31:0] pc, input logic pd,
                              input logic [31:0] inst);
        dec_t d;
        int   n = 0;
        while (dec_q.size() == 0 && n < TMO) begin
            step();
            n++;
        end
        check({tag, "_issued"}, 32'(dec_q.size() != 0), 32'd1);
        if (dec_q.size() != 0) begin
            d = dec_q.pop_front();
            check({tag, "_pc"}, d.pc, pc);
            check({tag, "_pd"}, 32'(d.pd), 32'(pd));
            check({tag, "_inst"}, d.inst, inst);
        end
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        int n = 0;
        while (req_q.size() == 0 && n < TMO) begin
            step();
            n++;
        end
        check({tag, "_requested"}, 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) check({tag, "_addr"}, req_q.pop_front(), addr);
    endtask

    task automatic wait_mc_rise(input string tag);
        logic prev = oMC_en;
        bit   found = 1'b0;
        for (int n = 0; n < TMO && !found; n++) begin
            step();
            if (oMC_en && !prev) found = 1'b1;
            prev = oMC_en;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic flush_to(input logic [31:0] target);
        iROB_clr = 1'b1;
        iROB_pc  = target;
        req_q.delete();
        dec_q.delete();
        step();
        iROB_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        req_q.delete();
        dec_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        iFULL    = 1'b0;
        iROB_clr = 1'b0;
        iROB_pc  = '0;
        repeat (3) step();

        // Reset values
        check("rst_mc_en",    32'(oMC_en),  32'd0);
        check("rst_mc_addr",  oMC_addr,     32'd0);
        check("rst_dec_en",   32'(oDEC_en), 32'd0);
        check("rst_dec_inst", oDEC_inst,    32'd0);
        check("rst_dec_pc",   oDEC_pc,      32'd0);
        check("rst_dec_pd",   32'(oDEC_pd), 32'd0);

        // First request and valid-to-issue latency
        rst = 1'b0;
        step();
        check("first_req_en",   32'(oMC_en), 32'd1);
        check("first_req_addr", oMC_addr,    32'd0);
        step();
        step();
        check("lat_not_early", 32'(oDEC_en), 32'd0);
        step();
        check("lat_dec_en",  32'(oDEC_en), 32'd1);
        check("lat_dec_pc",  oDEC_pc,      32'd0);
        check("lat_next_req", oMC_addr,    32'd4);

        // Sequential stream and JAL prediction at 0x10
        expect_dec("seq0",  32'h0,   1'b0, ADDI);
        expect_dec("seq4",  32'h4,   1'b0, ADDI);
        expect_dec("seq8",  32'h8,   1'b0, ADDI);
        expect_dec("seqC",  32'hC,   1'b0, ADDI);
        expect_dec("jal",   32'h10,  1'b1, JAL100);
        expect_dec("jal_t", 32'h110, 1'b0, ADDI);
        expect_req("req0",   32'h0);
        expect_req("req4",   32'h4);
        expect_req("req8",   32'h8);
        expect_req("reqC",   32'hC);
        expect_req("req10",  32'h10);
        expect_req("req110", 32'h110);

        // Flush while a request is outstanding
        wait_mc_rise("flush_find_wait");
        flush_to(32'h200);
        check("flush_dec_en", 32'(oDEC_en), 32'd0);
        check("flush_mc_held", 32'(oMC_en), 32'd1);
        expect_req("flush_req", 32'h200);
        expect_dec("flush_dec", 32'h200, 1'b0, ADDI);

        // Backward branch predicted taken, forward branch not taken
        flush_to(32'h20);
        expect_req("bneg_req", 32'h20);
        expect_dec("bneg",     32'h20, 1'b1, BEQ_NEG);
        expect_req("bneg_tgt", 32'h18);
        expect_dec("bneg_t",   32'h18, 1'b0, ADDI);
        beq_word = BEQ_POS;
        flush_to(32'h20);
        expect_req("bpos_req", 32'h20);
        expect_dec("bpos",     32'h20, 1'b0, BEQ_POS);
        expect_req("bpos_nxt", 32'h24);
        expect_dec("bpos_n",   32'h24, 1'b0, ADDI);

        // Downstream full: queue fills to four entries and fetching stops
        iFULL = 1'b1;
        do_reset();
        repeat (20) step();
        check("full_mc_idle", 32'(oMC_en),      32'd0);
        check("full_no_issue", 32'(oDEC_en),    32'd0);
        check("full_reqs",    32'(req_q.size()), 32'd4);
        expect_req("full_r0", 32'h0);
        expect_req("full_r4", 32'h4);
        expect_req("full_r8", 32'h8);
        expect_req("full_rC", 32'hC);
        iFULL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain%0d_en", i), 32'(oDEC_en), 32'd1);
            check($sformatf("drain%0d_pc", i), oDEC_pc,      32'(i * 4));
        end
        dec_q.delete();
        expect_req("resume_req", 32'h10);
        expect_dec("resume_dec", 32'h10, 1'b1, JAL100);

        // rdy low for three cycles with an issue pulse showing and a request pending
        do_reset();
        repeat (4) step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("frz%0d_dec_en", i), 32'(oDEC_en), 32'd1);
            check($sformatf("frz%0d_dec_pc", i), oDEC_pc,      32'd0);
            check($sformatf("frz%0d_mc_en", i),  32'(oMC_en),  32'd1);
            check($sformatf("frz%0d_mc_addr", i), oMC_addr,    32'd4);
        end
        rdy = 1'b1;
        expect_dec("frz_d0", 32'h0, 1'b0, ADDI);
        expect_dec("frz_d4", 32'h4, 1'b0, ADDI);
        expect_dec("frz_d8", 32'h8, 1'b0, ADDI);
        expect_req("frz_r0", 32'h0);
        expect_req("frz_r4", 32'h4);
        expect_req("frz_r8", 32'h8);

        // Reset mid-request; the late response lands in IDLE and must be ignored
        wait_mc_rise("rstmid_find_wait");
        mem_on    = 1'b0;
        man_valid = 1'b1;
        man_inst  = JAL100;
        rst       = 1'b1;
        req_q.delete();
        dec_q.delete();
        step();
        rst       = 1'b0;
        man_valid = 1'b0;
        check("rstmid_mc_en",  32'(oMC_en),  32'd0);
        check("rstmid_dec_en", 32'(oDEC_en), 32'd0);
        step();
        check("rstmid_req_en",   32'(oMC_en), 32'd1);
        check("rstmid_req_addr", oMC_addr,    32'd0);
        mem_on = 1'b1;
        expect_req("rstmid_r0", 32'h0);
        expect_dec("rstmid_d0", 32'h0, 1'b0, ADDI);
        expect_dec("rstmid_d4", 32'h4, 1'b0, ADDI);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
